// File: rtl/board_ctl_pkg.sv
// Shared definitions for the tic-tac-toe board controller and the draw stages.
package board_ctl_pkg;

    localparam int unsigned POS_W  = 12;
    localparam int unsigned NCELL  = 9;
    localparam int unsigned IDX_W  = 4;
    localparam int unsigned WIN_W  = 2;
    localparam int unsigned NLINES = 8;

    // Grid boundaries; the pixels between a MAX and the next MIN are grid lines.
    localparam logic [POS_W-1:0] COL0_MAX = POS_W'(340);
    localparam logic [POS_W-1:0] COL1_MIN = POS_W'(342);
    localparam logic [POS_W-1:0] COL1_MAX = POS_W'(683);
    localparam logic [POS_W-1:0] COL2_MIN = POS_W'(685);
    localparam logic [POS_W-1:0] COL2_MAX = POS_W'(1023);
    localparam logic [POS_W-1:0] ROW0_MAX = POS_W'(251);
    localparam logic [POS_W-1:0] ROW1_MIN = POS_W'(253);
    localparam logic [POS_W-1:0] ROW1_MAX = POS_W'(504);
    localparam logic [POS_W-1:0] ROW2_MIN = POS_W'(506);
    localparam logic [POS_W-1:0] ROW2_MAX = POS_W'(767);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PLAY  = 2'd1,
        ST_CHECK = 2'd2,
        ST_OVER  = 2'd3
    } state_e;

    localparam logic [WIN_W-1:0] WIN_NONE = 2'b00;
    localparam logic [WIN_W-1:0] WIN_X    = 2'b01;
    localparam logic [WIN_W-1:0] WIN_O    = 2'b10;
    localparam logic [WIN_W-1:0] WIN_DRAW = 2'b11;

    // Three cell indices of line l, packed {a, b, c}: rows, columns, diagonals.
    function automatic logic [3*IDX_W-1:0] line_cells(input int unsigned l);
        case (l)
            0:       return {4'd0, 4'd1, 4'd2};
            1:       return {4'd3, 4'd4, 4'd5};
            2:       return {4'd6, 4'd7, 4'd8};
            3:       return {4'd0, 4'd3, 4'd6};
            4:       return {4'd1, 4'd4, 4'd7};
            5:       return {4'd2, 4'd5, 4'd8};
            6:       return {4'd0, 4'd4, 4'd8};
            default: return {4'd2, 4'd4, 4'd6};
        endcase
    endfunction

endpackage

// File: rtl/board_ctl_cell_decode.sv
// Pixel position to board cell index; grid lines and off-screen are invalid.
module cell_decode
    import board_ctl_pkg::*;
(
    input  logic [POS_W-1:0] xpos_i,
    input  logic [POS_W-1:0] ypos_i,
    output logic [IDX_W-1:0] idx_o,
    output logic             valid_o
);

    logic [1:0]       col;
    logic [1:0]       row;
    logic             col_ok;
    logic             row_ok;
    logic [IDX_W-1:0] row_w;

    // Column and row bands, then idx = 3*row + col.
    always_comb begin
        col    = 2'd0;
        row    = 2'd0;
        col_ok = 1'b0;
        row_ok = 1'b0;
        if (xpos_i <= COL0_MAX) begin
            col    = 2'd0;
            col_ok = 1'b1;
        end else if (xpos_i >= COL1_MIN && xpos_i <= COL1_MAX) begin
            col    = 2'd1;
            col_ok = 1'b1;
        end else if (xpos_i >= COL2_MIN && xpos_i <= COL2_MAX) begin
            col    = 2'd2;
            col_ok = 1'b1;
        end
        if (ypos_i <= ROW0_MAX) begin
            row    = 2'd0;
            row_ok = 1'b1;
        end else if (ypos_i >= ROW1_MIN && ypos_i <= ROW1_MAX) begin
            row    = 2'd1;
            row_ok = 1'b1;
        end else if (ypos_i >= ROW2_MIN && ypos_i <= ROW2_MAX) begin
            row    = 2'd2;
            row_ok = 1'b1;
        end
        row_w   = IDX_W'(row);
        idx_o   = (row_w << 1) + row_w + IDX_W'(col);
        valid_o = col_ok & row_ok;
    end

endmodule

// File: rtl/board_ctl.sv
// Tic-tac-toe controller: mouse clicks claim cells, tracks turn and winner.
module board_ctl
    import board_ctl_pkg::*;
(
    input  logic             pclk,
    input  logic             rst_n,
    input  logic [POS_W-1:0] xpos,
    input  logic [POS_W-1:0] ypos,
    input  logic             mouse_left,
    input  logic             start_req,
    input  logic             restart,
    output logic             start_en,
    output logic [NCELL-1:0] square,
    output logic [NCELL-1:0] owner_o,
    output logic             turn_o,
    output logic [WIN_W-1:0] winner
);

    state_e           state_q;
    logic             start_en_q;
    logic [NCELL-1:0] square_q;
    logic [NCELL-1:0] owner_q;
    logic             turn_q;
    logic [WIN_W-1:0] winner_q;
    logic             mouse_left_q;
    logic             start_req_q;

    logic             click_c;
    logic             start_edge_c;
    logic [IDX_W-1:0] cell_idx;
    logic             cell_valid;
    logic [WIN_W-1:0] line_win_c;

    cell_decode u_cell_decode (
        .xpos_i  (xpos),
        .ypos_i  (ypos),
        .idx_o   (cell_idx),
        .valid_o (cell_valid)
    );

    // Winner of any full single-owner line, WIN_NONE if there is none.
    function automatic logic [WIN_W-1:0] line_winner(input logic [NCELL-1:0] sq,
                                                     input logic [NCELL-1:0] own);
        logic [WIN_W-1:0]   res;
        logic [3*IDX_W-1:0] c;
        logic [IDX_W-1:0]   a;
        logic [IDX_W-1:0]   b;
        logic [IDX_W-1:0]   d;
        res = WIN_NONE;
        for (int unsigned l = 0; l < NLINES; l++) begin
            c = line_cells(l);
            a = c[3*IDX_W-1:2*IDX_W];
            b = c[2*IDX_W-1:IDX_W];
            d = c[IDX_W-1:0];
            if (sq[a] && sq[b] && sq[d] && (own[a] == own[b]) && (own[b] == own[d]))
                res = own[a] ? WIN_O : WIN_X;
        end
        return res;
    endfunction

    // Rising-edge detection for the click and start request.
    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            mouse_left_q <= 1'b0;
            start_req_q  <= 1'b0;
        end else begin
            mouse_left_q <= mouse_left;
            start_req_q  <= start_req;
        end
    end

    // Edge pulses and line evaluation of the current board.
    always_comb begin
        click_c      = mouse_left & ~mouse_left_q;
        start_edge_c = start_req & ~start_req_q;
        line_win_c   = line_winner(square_q, owner_q);
    end

    // Game FSM with registered outputs; restart overrides every transition.
    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            start_en_q <= 1'b0;
            square_q   <= '0;
            owner_q    <= '0;
            turn_q     <= 1'b0;
            winner_q   <= WIN_NONE;
        end else if (restart) begin
            state_q    <= ST_IDLE;
            start_en_q <= 1'b0;
            square_q   <= '0;
            owner_q    <= '0;
            turn_q     <= 1'b0;
            winner_q   <= WIN_NONE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    square_q <= '0;
                    owner_q  <= '0;
                    turn_q   <= 1'b0;
                    winner_q <= WIN_NONE;
                    if (start_edge_c) begin
                        state_q    <= ST_PLAY;
                        start_en_q <= 1'b1;
                    end else begin
                        start_en_q <= 1'b0;
                    end
                end
                ST_PLAY: begin
                    if (click_c && cell_valid && !square_q[cell_idx]) begin
                        square_q[cell_idx] <= 1'b1;
                        owner_q[cell_idx]  <= turn_q;
                        state_q            <= ST_CHECK;
                    end
                end
                ST_CHECK: begin
                    if (line_win_c != WIN_NONE) begin
                        winner_q <= line_win_c;
                        state_q  <= ST_OVER;
                    end else if (&square_q) begin
                        winner_q <= WIN_DRAW;
                        state_q  <= ST_OVER;
                    end else begin
                        turn_q   <= ~turn_q;
                        state_q  <= ST_PLAY;
                    end
                end
                ST_OVER: begin
                    if (start_edge_c) begin
                        state_q    <= ST_IDLE;
                        start_en_q <= 1'b0;
                        square_q   <= '0;
                        owner_q    <= '0;
                        turn_q     <= 1'b0;
                        winner_q   <= WIN_NONE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign start_en = start_en_q;
    assign square   = square_q;
    assign owner_o  = owner_q;
    assign turn_o   = turn_q;
    assign winner   = winner_q;

endmodule
